// File: rtl/sms_mem_pkg.sv
// sms_mem_pkg: shared types and constants for the
// ROM download write / cartridge read responder.
package sms_mem_pkg;

  localparam int DEF_AW = 22;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_WR = 2'd1,
    ISSUE_RD = 2'd2,
    WAIT_RD  = 2'd3
  } state_t;

  // Odd byte addresses live in the high half of the word.
  function automatic logic [1:0] byte_be(input logic odd);
    return odd ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/lat_counter.sv
// lat_counter: 3-bit down-counter timing the read return.
// tc marks the cycle the memory read data is valid.
module lat_counter (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       en,
  output logic       tc
);

  logic [2:0] cnt;

  // Load on read acceptance, then count down while waiting.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign tc = en && (cnt == 3'd1);

endmodule

// File: rtl/rom_wr_responder.sv
// rom_wr_responder: arbitrates toggle-handshake byte writes and
// cartridge byte reads onto one 16-bit synchronous memory port.
module rom_wr_responder
  import sms_mem_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int RD_LAT = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    din,
  output logic          we_ack,
  input  logic          rd,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    dout,
  output logic          rd_rdy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-2:0] mem_addr,
  output logic [1:0]    mem_be,
  output logic [15:0]   mem_din,
  input  logic          mem_busy,
  input  logic [15:0]   mem_dout
);

  state_t        state;
  logic          rd_pend;
  logic [AW-1:0] ra;
  logic          bsel;

  logic          wr_pend;
  logic          rd_any;
  logic [AW-1:0] ra_nx;
  logic          accept;
  logic          cnt_load;
  logic          cnt_tc;

  assign wr_pend  = we ^ we_ack;
  assign rd_any   = rd | rd_pend;
  assign ra_nx    = rd ? raddr : ra;
  assign accept   = mem_req & ~mem_busy;
  assign cnt_load = (state == ISSUE_RD) && accept;

  lat_counter u_lat (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (3'(RD_LAT)),
    .en       (state == WAIT_RD),
    .tc       (cnt_tc)
  );

  // Request sampling, arbitration and the registered memory port.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      we_ack   <= we;
      rd_pend  <= 1'b0;
      ra       <= '0;
      bsel     <= 1'b0;
      dout     <= 8'h00;
      rd_rdy   <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_be   <= 2'b00;
      mem_addr <= '0;
      mem_din  <= 16'h0000;
    end else begin
      rd_rdy <= 1'b0;
      if (rd) begin
        rd_pend <= 1'b1;
        ra      <= raddr;
      end
      unique case (state)
        IDLE: begin
          if (rd_any) begin
            state <= ISSUE_RD;
          end else if (wr_pend) begin
            state <= ISSUE_WR;
          end
        end
        ISSUE_WR: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= waddr[AW-1:1];
            mem_be   <= byte_be(waddr[0]);
            mem_din  <= {din, din};
          end else if (!mem_busy) begin
            mem_req <= 1'b0;
            we_ack  <= we;
            state   <= IDLE;
          end
        end
        ISSUE_RD: begin
          // Keep following the newest read address until accepted.
          if (!accept) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= ra_nx[AW-1:1];
            mem_be   <= BE_WORD;
          end else begin
            mem_req <= 1'b0;
            bsel    <= ra[0];
            state   <= WAIT_RD;
            if (!rd) begin
              rd_pend <= 1'b0;
            end
          end
        end
        WAIT_RD: begin
          if (cnt_tc) begin
            dout   <= bsel ? mem_dout[15:8] : mem_dout[7:0];
            rd_rdy <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_wr_responder.sv
// tb_rom_wr_responder: directed checks of the write/read
// responder against a small 16-bit memory model.
module tb_rom_wr_responder;

  localparam int AW     = 22;
  localparam int RD_LAT = 2;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    din;
  logic          we_ack;
  logic          rd;
  logic [AW-1:0] raddr;
  logic [7:0]    dout;
  logic          rd_rdy;
  logic          mem_req;
  logic          mem_we;
  logic [AW-2:0] mem_addr;
  logic [1:0]    mem_be;
  logic [15:0]   mem_din;
  logic          mem_busy;
  logic [15:0]   mem_dout;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int n_rdy = 0;
  int n_ack = 0;
  logic ack_q = 1'b0;

  logic [15:0] mem [0:2047];
  logic [15:0] pd  [1:RD_LAT];
  logic        pv  [1:RD_LAT];
  logic [7:0]  src [0:1023];

  always #5 clk_sys = ~clk_sys;

  rom_wr_responder #(.AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .we       (we),
    .waddr    (waddr),
    .din      (din),
    .we_ack   (we_ack),
    .rd       (rd),
    .raddr    (raddr),
    .dout     (dout),
    .rd_rdy   (rd_rdy),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_din  (mem_din),
    .mem_busy (mem_busy),
    .mem_dout (mem_dout)
  );

  assign mem_dout = pv[RD_LAT] ? pd[RD_LAT] : 16'hDEAD;

  // Memory model: byte-enabled writes, reads return after RD_LAT.
  always @(posedge clk_sys) begin
    if (mem_req && !mem_busy && mem_we) begin
      n_wr++;
      if (mem_be[1]) mem[mem_addr[10:0]][15:8] = mem_din[15:8];
      if (mem_be[0]) mem[mem_addr[10:0]][7:0]  = mem_din[7:0];
    end
    pv[1] <= mem_req && !mem_busy && !mem_we;
    pd[1] <= mem[mem_addr[10:0]];
    for (int i = 2; i <= RD_LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end

  // Event counters for pulses and toggle edges.
  always @(posedge clk_sys) begin
    if (rd_rdy === 1'b1) n_rdy++;
    if (we_ack !== ack_q) n_ack++;
    ack_q = we_ack;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int s_wr;
    int s_rdy;
    int s_ack;
    int tmo;
    int badb;
    int k;
    logic [15:0] w;
    logic [7:0]  b;

    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    for (int i = 1; i <= RD_LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = 16'h0000;
    end
    mem[8] = 16'h1234;
    mem[9] = 16'hBEEF;

    reset = 1'b1; we = 1'b0; rd = 1'b0; mem_busy = 1'b0;
    waddr = '0; raddr = '0; din = 8'h00;
    tick(); tick(); tick();
    chk("rst_we_ack", 32'(we_ack), 32'd0);
    chk("rst_rd_rdy", 32'(rd_rdy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    reset = 1'b0;
    tick();

    // Single write: byte 3 -> word 1, high byte.
    din = 8'hA5; waddr = 22'h000003; we = 1'b1;
    tick();
    chk("wr1_c1_req", 32'(mem_req), 32'd0);
    tick();
    chk("wr1_c2_req", 32'(mem_req), 32'd1);
    chk("wr1_c2_we", 32'(mem_we), 32'd1);
    chk("wr1_c2_addr", 32'(mem_addr), 32'd1);
    chk("wr1_c2_be", 32'(mem_be), 32'd2);
    chk("wr1_c2_din", 32'(mem_din), 32'hA5A5);
    chk("wr1_c2_ack", 32'(we_ack), 32'd0);
    tick();
    chk("wr1_c3_ack", 32'(we_ack), 32'd1);
    chk("wr1_c3_req", 32'(mem_req), 32'd0);
    chk("wr1_count", 32'(n_wr), 32'd1);
    chk("wr1_mem", 32'(mem[1]), 32'hA500);

    // Stalled write: busy high for 10 cycles.
    din = 8'h5A; waddr = 22'h000004; we = 1'b0; mem_busy = 1'b1;
    tick(); tick();
    chk("wrs_c2_req", 32'(mem_req), 32'd1);
    for (int i = 0; i < 8; i++) tick();
    chk("wrs_c10_req", 32'(mem_req), 32'd1);
    chk("wrs_c10_addr", 32'(mem_addr), 32'd2);
    chk("wrs_c10_be", 32'(mem_be), 32'd1);
    chk("wrs_c10_din", 32'(mem_din), 32'h5A5A);
    chk("wrs_c10_ack", 32'(we_ack), 32'd1);
    mem_busy = 1'b0;
    tick();
    chk("wrs_c11_ack", 32'(we_ack), 32'd0);
    chk("wrs_count", 32'(n_wr), 32'd2);
    chk("wrs_mem", 32'(mem[2]), 32'h005A);

    // Single read, low byte then high byte.
    s_rdy = n_rdy;
    rd = 1'b1; raddr = 22'h000010;
    tick();
    rd = 1'b0;
    tick();
    chk("rd1_c2_req", 32'(mem_req), 32'd1);
    chk("rd1_c2_we", 32'(mem_we), 32'd0);
    chk("rd1_c2_addr", 32'(mem_addr), 32'd8);
    chk("rd1_c2_be", 32'(mem_be), 32'd3);
    tick(); tick();
    chk("rd1_c4_rdy", 32'(rd_rdy), 32'd0);
    tick();
    chk("rd1_c5_rdy", 32'(rd_rdy), 32'd1);
    chk("rd1_c5_dout", 32'(dout), 32'h34);
    tick();
    chk("rd1_c6_rdy", 32'(rd_rdy), 32'd0);
    chk("rd1_c6_dout", 32'(dout), 32'h34);
    chk("rd1_pulses", 32'(n_rdy - s_rdy), 32'd1);

    rd = 1'b1; raddr = 22'h000011;
    tick();
    rd = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rd2_c5_rdy", 32'(rd_rdy), 32'd1);
    chk("rd2_c5_dout", 32'(dout), 32'h12);
    tick();

    // Read and write in the same cycle: read goes first.
    s_rdy = n_rdy; s_ack = n_ack; s_wr = n_wr;
    rd = 1'b1; raddr = 22'h000010;
    we = 1'b1; waddr = 22'h000006; din = 8'hC3;
    tick();
    rd = 1'b0;
    tick();
    chk("rw_c2_req", 32'(mem_req), 32'd1);
    chk("rw_c2_we", 32'(mem_we), 32'd0);
    tick(); tick(); tick();
    chk("rw_c5_rdy", 32'(rd_rdy), 32'd1);
    chk("rw_c5_dout", 32'(dout), 32'h34);
    chk("rw_c5_ack", 32'(we_ack), 32'd0);
    tick(); tick();
    chk("rw_c7_we", 32'(mem_we), 32'd1);
    chk("rw_c7_addr", 32'(mem_addr), 32'd3);
    chk("rw_c7_be", 32'(mem_be), 32'd1);
    tick();
    chk("rw_c8_ack", 32'(we_ack), 32'd1);
    tick(); tick();
    chk("rw_pulses", 32'(n_rdy - s_rdy), 32'd1);
    chk("rw_acks", 32'(n_ack - s_ack), 32'd1);
    chk("rw_writes", 32'(n_wr - s_wr), 32'd1);

    // Read replaced while stalled: newest address wins.
    s_rdy = n_rdy;
    mem_busy = 1'b1; rd = 1'b1; raddr = 22'h000010;
    tick();
    rd = 1'b0;
    tick();
    chk("rr_c2_addr", 32'(mem_addr), 32'd8);
    rd = 1'b1; raddr = 22'h000013;
    tick();
    rd = 1'b0;
    chk("rr_c3_addr", 32'(mem_addr), 32'd9);
    chk("rr_c3_req", 32'(mem_req), 32'd1);
    mem_busy = 1'b0;
    tick(); tick(); tick();
    chk("rr_c6_rdy", 32'(rd_rdy), 32'd1);
    chk("rr_c6_dout", 32'(dout), 32'hBE);
    for (int i = 0; i < 6; i++) tick();
    chk("rr_pulses", 32'(n_rdy - s_rdy), 32'd1);

    // Reset during WAIT_RD: no pulse, dout cleared.
    s_rdy = n_rdy;
    rd = 1'b1; raddr = 22'h000010;
    tick();
    rd = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rwt_pulses", 32'(n_rdy - s_rdy), 32'd0);
    chk("rwt_dout", 32'(dout), 32'd0);

    // Reset with a stalled write pending and we=1: resync, no write.
    we = 1'b0; waddr = 22'h000008; din = 8'h11;
    for (int i = 0; i < 4; i++) tick();
    chk("rs_pre_ack", 32'(we_ack), 32'd0);
    mem_busy = 1'b1; we = 1'b1;
    tick(); tick(); tick();
    chk("rs_stall_req", 32'(mem_req), 32'd1);
    s_wr = n_wr;
    reset = 1'b1;
    tick();
    mem_busy = 1'b0;
    tick();
    reset = 1'b0;
    chk("rs_ack", 32'(we_ack), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("rs_no_write", 32'(n_wr - s_wr), 32'd0);
    chk("rs_req", 32'(mem_req), 32'd0);
    chk("rs_ack_hold", 32'(we_ack), 32'd1);

    // Download stream: 1024 bytes with random stalls.
    s_wr = n_wr; s_ack = n_ack; tmo = 0;
    for (int i = 0; i < 1024; i++) begin
      src[i] = 8'($urandom);
      waddr  = AW'(32'h400 + i);
      din    = src[i];
      we     = ~we;
      k = 0;
      while (we_ack !== we && k < 64) begin
        mem_busy = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      if (k >= 64) tmo++;
    end
    mem_busy = 1'b0;
    tick(); tick();
    badb = 0;
    for (int i = 0; i < 1024; i++) begin
      w = mem[(32'h400 + i) >> 1];
      b = i[0] ? w[15:8] : w[7:0];
      if (b !== src[i]) badb++;
    end
    chk("dl_timeouts", 32'(tmo), 32'd0);
    chk("dl_writes", 32'(n_wr - s_wr), 32'd1024);
    chk("dl_acks", 32'(n_ack - s_ack), 32'd1024);
    chk("dl_image_bad", 32'(badb), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
